seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Parametrised, programmable sequence generator that replays a software-loaded table of DATA_W-bit words over a valid/ready stream. It is the next generation of the fixed 8-entry sequence generator. It adds a runtime-writable table, a programmable sequence length, one-shot/loop/ping-pong modes, start/stop control and downstream backpressure. It sits between a register-file write port and any stream consumer (DAC shim, test-pattern mux, serializer).

## Interface
- DATA_W, 8, output word width
- DEPTH, 8, table entries (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), table index width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write index; ignored if > DEPTH-1
- wr_data  in  DATA_W  table write data
- len  in  ADDR_W  last index of the sequence (sequence = entries 0..len)
- mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 treated as loop
- start  in  1  begin sequence (IDLE only)
- stop  in  1  abort sequence
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  current table word
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, one-shot completed
- wrap  out  1  one-cycle pulse, loop/ping-pong period completed

## Operation
- Reset values: all table entries 0, out_data 0, out_valid 0, busy 0, done 0, wrap 0, idx 0, dir up, state IDLE. Reset asserted mid-sequence aborts immediately; no done/wrap is emitted.
- fire = out_valid & out_ready.
- States: IDLE, RUN.
  - IDLE→RUN on start: latch mode and min(len, DEPTH-1) into internal registers, load out_data ← table[0], idx ← 0, dir ← up.
  - RUN→IDLE on stop, or on one-shot fire at idx == len.
  - start in RUN is ignored. mode/len changes in RUN have no effect.
- Index advance on fire:
  - One-shot: idx+1; at idx == len go IDLE, pulse done.
  - Loop: idx == len → 0 and pulse wrap, else idx+1.
  - Ping-pong: bounce between 0 and len without repeating endpoints (len=3 gives 0,1,2,3,2,1,0,1,…). Pulse wrap on the fire of idx 0 while descending. With len=0 the output is entry 0 every beat, with wrap on every fire.
- out_data is a registered snapshot, loaded only on start and on fire with table[next idx]. It is stable while out_valid & !out_ready. The consumer never sees a mid-beat change.
- Table writes are accepted in any state. A write to the entry currently held in out_data does not alter that beat. A write in the same cycle as a load of the same address forwards wr_data (write-first).
- stop has priority over start and advance. If stop coincides with fire, that beat counts as transferred, but no further beat, done or wrap follows.

## Timing
- start at cycle N → out_valid=1, busy=1, out_data=table[0] at N+1.
- Fire at cycle N → next word on out_data at N+1. Full throughput (one beat per cycle) with out_ready held high.
- One-shot: exactly len+1 beats. done=1 in the cycle after the final fire, coinciding with out_valid=0 and busy=0.
- wrap: high in the cycle after the qualifying fire.
- stop at N → out_valid=0, busy=0 at N+1.
- Table write at N is visible to any load at cycle ≥ N (forwarding at N).

## Test plan
- Reset, write 0xAF,0xBC,0xE2,0x78 to 0..3, len=3, one-shot, ready=1 → beats AF,BC,E2,78 on 4 consecutive cycles, done pulse 1 cycle after 78, then out_valid=0.
- Loop, len=2, ready=1 for 7 fires → AF,BC,E2,AF,BC,E2,AF; wrap pulses after each E2.
- Ping-pong, len=3 → AF,BC,E2,78,E2,BC,AF,BC; wrap after the second AF. Repeat with len=0 → AF each beat, wrap each fire.
- Backpressure: out_ready toggled 1,0,0,1 → out_data held constant while stalled; no beats lost or duplicated. Write 0x55 to the held entry mid-stall → beat unchanged; the next pass emits 0x55.
- stop coincident with fire, then start same cycle as stop → one beat transferred, IDLE next cycle, no done/wrap, start ignored. rst_n asserted mid-RUN → all outputs 0 asynchronously and table cleared.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: replays a runtime-writable table of DATA_W-bit words over a
// valid/ready stream in one-shot, loop or ping-pong order.
module seq_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] len,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [1:0] {
    M_ONESHOT  = 2'b00,
    M_LOOP     = 2'b01,
    M_PINGPONG = 2'b10,
    M_LOOP_ALT = 2'b11
  } mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam int unsigned       LAST     = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  dir_t                dir_q, dir_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   tbl [DEPTH];

  logic                load;
  logic [ADDR_W-1:0]   load_addr;
  logic [DATA_W-1:0]   load_word;
  logic [ADDR_W-1:0]   len_clamped;
  logic                wr_ok;

  assign len_clamped = (32'(len) > LAST) ? LAST_IDX : len;
  assign wr_ok       = wr_en && (32'(wr_addr) <= LAST);
  // Write-first: a load of the address being written this cycle takes wr_data.
  assign load_word   = (wr_ok && (wr_addr == load_addr)) ? wr_data : tbl[load_addr];

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign out_data  = data_q;

  // Next-state, index advance and load selection.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode_t'(mode);
          len_d   = len_clamped;
          idx_d   = '0;
          dir_d   = DIR_UP;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (out_ready) begin
          case (mode_q)
            M_ONESHOT: begin
              if (idx_q == len_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + ONE;
                load  = 1'b1;
              end
            end
            M_PINGPONG: begin
              load = 1'b1;
              if (len_q == '0) begin
                wrap_d = 1'b1;
              end else if (dir_q == DIR_UP) begin
                if (idx_q == len_q) begin
                  dir_d = DIR_DOWN;
                  idx_d = idx_q - ONE;
                end else begin
                  idx_d = idx_q + ONE;
                end
              end else begin
                // Leaving index 0 on the way down closes a period; the next
                // beat is index 1 so the endpoint is not repeated.
                if (idx_q == '0) begin
                  wrap_d = 1'b1;
                  dir_d  = DIR_UP;
                  idx_d  = ONE;
                end else begin
                  idx_d = idx_q - ONE;
                end
              end
            end
            default: begin
              load = 1'b1;
              if (idx_q == len_q) begin
                idx_d  = '0;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q + ONE;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    load_addr = idx_d;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= M_ONESHOT;
      dir_q   <= DIR_UP;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Pattern table, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Output word snapshot, changed only on start or fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_word;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: directed vector table, hand-written corner
// sequences and randomized traffic against a beat-count reference model.
module tb_seq_pattern_gen;

  localparam int DW = 8;
  localparam int DP = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] len = '0;
  logic [1:0]    mode = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          wrap;

  seq_pattern_gen #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .mode(mode), .start(start), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beat number k within the current run, index derived arithmetically.
  logic [DW-1:0] m_tbl [DP];
  logic [DW-1:0] m_data;
  bit            m_run;
  int            m_k, m_L;
  logic [1:0]    m_mode;
  bit            e_done, e_wrap;

  function automatic int idx_of(input int k, input int L, input logic [1:0] md);
    int p;
    if (md == 2'b00) return k;
    if (md == 2'b10) begin
      if (L == 0) return 0;
      p = k % (2 * L);
      return (p <= L) ? p : 2 * L - p;
    end
    return k % (L + 1);
  endfunction

  function automatic bit wraps_at(input int k, input int L, input logic [1:0] md);
    if (md == 2'b10) return (L == 0) ? 1'b1 : ((k % (2 * L) == 0) && (k > 0));
    return (k % (L + 1)) == L;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_tbl[i] = '0;
    m_data = '0; m_run = 0; m_k = 0; m_L = 0; m_mode = '0;
    e_done = 0; e_wrap = 0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (wr_en && int'(wr_addr) < DP) m_tbl[wr_addr] = wr_data;
    e_done = 0;
    e_wrap = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_run  = 1;
        m_k    = 0;
        m_L    = (int'(len) > DP - 1) ? DP - 1 : int'(len);
        m_mode = mode;
        m_data = m_tbl[0];
      end
    end else if (stop) begin
      m_run = 0;
    end else if (out_ready) begin
      if (m_mode == 2'b00 && m_k == m_L) begin
        m_run  = 0;
        e_done = 1;
      end else begin
        e_wrap = wraps_at(m_k, m_L, m_mode);
        m_k++;
        m_data = m_tbl[idx_of(m_k, m_L, m_mode)];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, out_valid, m_run);
    chk({tag, " busy"}, busy, m_run);
    chk({tag, " done"}, done, e_done);
    chk({tag, " wrap"}, wrap, e_wrap);
    if (m_run) chk({tag, " data"}, out_data, m_data);
  endtask

  task automatic set_idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop = 0; out_ready = 0;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    bit          st, sp, rdy;
    logic [2:0]  ln;
    logic [1:0]  md;
    bit          ev;
    logic [7:0]  ed;
    bit          cd;
    bit          edn, ew;
  } vec_t;

  function automatic vec_t v(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                             input bit st, input bit sp, input bit rdy,
                             input logic [2:0] ln, input logic [1:0] md,
                             input bit ev, input logic [7:0] ed, input bit cd,
                             input bit edn, input bit ew);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.st = st; r.sp = sp; r.rdy = rdy;
    r.ln = ln; r.md = md; r.ev = ev; r.ed = ed; r.cd = cd; r.edn = edn; r.ew = ew;
    return r;
  endfunction

  vec_t vecs[$];
  logic [DW-1:0] held;

  initial begin
    // Table fill, then one-shot len=3
    vecs.push_back(v(1,0,8'hAF, 0,0,1, 0,0, 0,8'h00,1, 0,0));
    vecs.push_back(v(1,1,8'hBC, 0,0,1, 0,0, 0,8'h00,1, 0,0));
    vecs.push_back(v(1,2,8'hE2, 0,0,1, 0,0, 0,8'h00,1, 0,0));
    vecs.push_back(v(1,3,8'h78, 0,0,1, 0,0, 0,8'h00,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 1,0,1, 3,0, 1,8'hAF,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,0, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,0, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,0, 1,8'h78,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,0, 0,8'h00,0, 1,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,0, 0,8'h00,0, 0,0));
    // Loop len=2, seven fires
    vecs.push_back(v(0,0,8'h00, 1,0,1, 2,1, 1,8'hAF,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hAF,1, 0,1));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hAF,1, 0,1));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 2,1, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,1,0, 2,1, 0,8'h00,0, 0,0));
    // Ping-pong len=3, stop coincident with a fire
    vecs.push_back(v(0,0,8'h00, 1,0,1, 3,2, 1,8'hAF,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'h78,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hBC,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hAF,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hBC,1, 0,1));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 3,2, 1,8'hE2,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,1,1, 3,2, 0,8'h00,0, 0,0));
    // Ping-pong len=0
    vecs.push_back(v(0,0,8'h00, 1,0,1, 0,2, 1,8'hAF,1, 0,0));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 0,2, 1,8'hAF,1, 0,1));
    vecs.push_back(v(0,0,8'h00, 0,0,1, 0,2, 1,8'hAF,1, 0,1));
    vecs.push_back(v(0,0,8'h00, 0,1,0, 0,2, 0,8'h00,0, 0,0));

    // Reset state
    model_reset();
    set_idle();
    repeat (2) @(negedge clk);
    chk("reset valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wrap", wrap, 0);
    chk("reset data", out_data, 0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      start = vecs[i].st; stop = vecs[i].sp; out_ready = vecs[i].rdy;
      len = vecs[i].ln; mode = vecs[i].md;
      step();
      chk($sformatf("vec%0d valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].ev);
      chk($sformatf("vec%0d done", i), done, vecs[i].edn);
      chk($sformatf("vec%0d wrap", i), wrap, vecs[i].ew);
      if (vecs[i].cd) chk($sformatf("vec%0d data", i), out_data, vecs[i].ed);
    end
    set_idle();

    // Backpressure 1,0,0,1 in mode 11 (loop), write to the held entry mid-stall
    mode = 2'b11; len = 3; start = 1; step(); check_model("bp start"); start = 0;
    out_ready = 1; step(); check_model("bp r1");
    held = out_data;
    out_ready = 0; step(); check_model("bp r0a");
    chk("bp hold a", out_data, 8'hBC);
    wr_en = 1; wr_addr = 1; wr_data = 8'h55;
    step(); check_model("bp r0b");
    chk("bp hold b", out_data, held);
    wr_en = 0;
    out_ready = 1; step(); check_model("bp r1b");
    chk("bp after stall", out_data, 8'hE2);
    step(); check_model("bp p1");
    step(); check_model("bp p2");
    step(); check_model("bp p3");
    chk("bp new word", out_data, 8'h55);
    stop = 1; step(); check_model("bp stop"); set_idle();

    // stop with fire and start in the same cycle
    mode = 2'b01; len = 2; start = 1; step(); check_model("ss start"); start = 0;
    out_ready = 1; step(); check_model("ss fire");
    stop = 1; start = 1; step(); check_model("ss stop");
    chk("ss valid", out_valid, 0);
    chk("ss wrap", wrap, 0);
    stop = 0; start = 0; step(); check_model("ss idle");
    chk("ss stays idle", busy, 0);
    chk("ss no done", done, 0);

    // Asynchronous reset mid-run clears outputs and table
    mode = 2'b01; len = 2; start = 1; out_ready = 1; step(); start = 0;
    step(); check_model("ar run");
    #2 rst_n = 1'b0;
    #1;
    chk("ar valid", out_valid, 0);
    chk("ar busy", busy, 0);
    chk("ar done", done, 0);
    chk("ar wrap", wrap, 0);
    chk("ar data", out_data, 0);
    model_reset();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b01; len = 7; start = 1; out_ready = 1;
    step(); check_model("ar clr0"); start = 0;
    chk("ar table 0", out_data, 0);
    for (int i = 1; i < 6; i++) begin
      step(); check_model("ar clr");
      chk($sformatf("ar table %0d", i), out_data, 0);
    end
    set_idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = DW'($urandom);
      len       = AW'($urandom_range(0, 7));
      mode      = 2'($urandom_range(0, 3));
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
